// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM states, the
// per-stage control bundle and helpers that build the two bundle shapes.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_ld;
    logic if_id_ld;
    logic id_ex_ld;
    logic ex_mem_ld;
    logic mem_wb_ld;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
  } stage_ctrl_t;

  // Whole pipeline frozen behind the memory access; MEM/WB takes a bubble.
  function automatic stage_ctrl_t freeze_ctrl();
    stage_ctrl_t c;
    c               = '0;
    c.mem_wb_ld     = 1'b1;
    c.mem_wb_bubble = 1'b1;
    return c;
  endfunction

  // Advance with hazard handling; branch outranks load-use, which outranks jump.
  function automatic stage_ctrl_t advance_ctrl(input logic branch,
                                               input logic load_use,
                                               input logic jump);
    stage_ctrl_t c;
    c           = '0;
    c.pc_ld     = 1'b1;
    c.if_id_ld  = 1'b1;
    c.id_ex_ld  = 1'b1;
    c.ex_mem_ld = 1'b1;
    c.mem_wb_ld = 1'b1;
    if (branch) begin
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (load_use) begin
      c.pc_ld       = 1'b0;
      c.if_id_ld    = 1'b0;
      c.id_ex_flush = 1'b1;
    end else if (jump) begin
      c.if_id_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the ID instruction.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rt,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_write_reg,
  output logic       o_stall
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_ex_write_reg == i_id_rs);
  assign w_rt_match = i_id_uses_rt && (i_ex_write_reg == i_id_rt);
  // Register zero is hardwired, so a load targeting it never creates a hazard.
  assign o_stall    = i_ex_mem_read && (i_ex_write_reg != REG_ZERO) &&
                      (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the five-stage pipeline. Outputs are
// combinational from state and inputs; memory waits freeze everything.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Jump,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WriteReg,
  input  logic             EX_BranchTaken,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic             Dmem_Ack,
  output logic             PC_Ld,
  output logic             IF_ID_Ld,
  output logic             ID_EX_Ld,
  output logic             EX_MEM_Ld,
  output logic             MEM_WB_Ld,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             MEM_WB_Bubble,
  output logic             Dmem_Req,
  output logic             Mem_Timeout,
  output logic [CNT_W-1:0] Stall_Count,
  output state_t           Dbg_State
);

  localparam int WCNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic [WCNT_W-1:0] w_wait_inc;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_mem_access;
  logic              w_miss;
  logic              w_load_use;
  logic              w_timeout_hit;
  logic              w_dmem_req;
  logic              w_fault_flag;
  stage_ctrl_t       w_ctrl;

  hazard_detect u_hazard_detect (
    .i_id_rs        (ID_Rs),
    .i_id_rt        (ID_Rt),
    .i_id_uses_rt   (ID_UsesRt),
    .i_ex_mem_read  (EX_MemRead),
    .i_ex_write_reg (EX_WriteReg),
    .o_stall        (w_load_use)
  );

  assign w_mem_access  = MEM_MemRead | MEM_MemWrite;
  assign w_miss        = w_mem_access && !Dmem_Ack;
  assign w_wait_inc    = r_wait_cnt + WCNT_W'(1);
  assign w_timeout_hit = (MEM_TIMEOUT != 0) && (w_wait_inc == WCNT_W'(MEM_TIMEOUT));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= RUN;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN:      if (w_miss) w_next_state = MEM_WAIT;
      MEM_WAIT: begin
        if (Dmem_Ack)           w_next_state = RUN;
        else if (w_timeout_hit) w_next_state = FAULT;
      end
      FAULT:    w_next_state = FAULT;
      default:  w_next_state = RUN;
    endcase
  end

  always_comb begin
    w_ctrl       = '0;
    w_dmem_req   = 1'b0;
    w_fault_flag = 1'b0;
    if (Rst) begin
      case (r_state)
        RUN: begin
          w_dmem_req = w_mem_access;
          w_ctrl     = w_miss ? freeze_ctrl()
                              : advance_ctrl(EX_BranchTaken, w_load_use, ID_Jump);
        end
        // The ack cycle resolves hazards that were held frozen during the wait.
        MEM_WAIT: begin
          w_dmem_req = w_mem_access;
          w_ctrl     = Dmem_Ack ? advance_ctrl(EX_BranchTaken, w_load_use, ID_Jump)
                                : freeze_ctrl();
        end
        FAULT:   w_fault_flag = 1'b1;
        default: w_ctrl = '0;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                                 r_wait_cnt <= '0;
    else if (r_state == MEM_WAIT && !Dmem_Ack) r_wait_cnt <= w_wait_inc;
    else                                      r_wait_cnt <= '0;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                                    r_stall_cnt <= '0;
    else if (!w_ctrl.pc_ld && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign PC_Ld         = w_ctrl.pc_ld;
  assign IF_ID_Ld      = w_ctrl.if_id_ld;
  assign ID_EX_Ld      = w_ctrl.id_ex_ld;
  assign EX_MEM_Ld     = w_ctrl.ex_mem_ld;
  assign MEM_WB_Ld     = w_ctrl.mem_wb_ld;
  assign IF_ID_Flush   = w_ctrl.if_id_flush;
  assign ID_EX_Flush   = w_ctrl.id_ex_flush;
  assign MEM_WB_Bubble = w_ctrl.mem_wb_bubble;
  assign Dmem_Req      = w_dmem_req;
  assign Mem_Timeout   = w_fault_flag;
  assign Stall_Count   = r_stall_cnt;
  assign Dbg_State     = r_state;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage pipeline. It drives the load-enable and flush strobes of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards, squashes wrong-path instructions on taken branches and jumps, and handshakes with the data memory to freeze the pipeline during multi-cycle accesses. It also keeps a saturating stall counter and a sticky memory-timeout fault flag.

## Interface
- MEM_TIMEOUT, 255: MEM_WAIT cycles before fault; 0 disables the timeout.
- CNT_W, 16: width of Stall_Count.

Ports:
- Clk  in  1  pipeline clock; all state changes on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- ID_Rs, ID_Rt  in  5  source register numbers of the instruction in ID.
- ID_UsesRt  in  1  the ID instruction reads Rt.
- ID_Jump  in  1  the ID instruction is j/jal/jr.
- EX_MemRead  in  1  the EX instruction is a load.
- EX_WriteReg  in  5  destination register of the EX instruction, after the RegDst mux.
- EX_BranchTaken  in  1  a branch resolved taken in EX.
- MEM_MemRead, MEM_MemWrite  in  1  the MEM instruction accesses data memory.
- Dmem_Ack  in  1  data memory completes the access this cycle.
- PC_Ld, IF_ID_Ld, ID_EX_Ld, EX_MEM_Ld, MEM_WB_Ld  out  1  stage load enables.
- IF_ID_Flush, ID_EX_Flush  out  1  with the matching Ld, load a NOP (all-zero) instead of upstream data.
- MEM_WB_Bubble  out  1  with MEM_WB_Ld, load a NOP into MEM/WB.
- Dmem_Req  out  1  data-memory request.
- Mem_Timeout  out  1  sticky fault flag.
- Stall_Count  out  CNT_W  saturating count of cycles with PC_Ld=0.

## Operation
- States: RUN, MEM_WAIT, FAULT.
- All outputs are combinational from state and inputs. While Rst=0, every output is 0 and Stall_Count is 0.
- Dmem_Req = (MEM_MemRead | MEM_MemWrite) in RUN or MEM_WAIT; it is 0 in FAULT.
- RUN, memory miss: Dmem_Req=1 and Dmem_Ack=0.
  - Next state is MEM_WAIT.
  - This cycle: all Ld=0 except MEM_WB_Ld=1 with MEM_WB_Bubble=1.
- RUN, taken branch: EX_BranchTaken=1 and no miss.
  - All Ld=1; IF_ID_Flush=1 and ID_EX_Flush=1.
  - This squashes two wrong-path instructions. The PC loads the target.
- RUN, load-use: EX_MemRead=1, EX_WriteReg≠0, and EX_WriteReg matches ID_Rs, or matches ID_Rt with ID_UsesRt=1.
  - PC_Ld=0 and IF_ID_Ld=0.
  - ID_EX_Ld=1 with ID_EX_Flush=1 (one bubble).
  - EX_MEM_Ld=1 and MEM_WB_Ld=1.
- RUN, jump: ID_Jump=1 and none of the above. All Ld=1, IF_ID_Flush=1.
- RUN, otherwise: all Ld=1, no flushes.
- Priority: memory miss > taken branch > load-use > jump.
  - A branch that coincides with a miss stays frozen in EX and is re-evaluated after the stall.
- MEM_WAIT, Dmem_Ack=0:
  - Same outputs as a RUN miss cycle.
  - The wait counter increments.
  - When the counter reaches MEM_TIMEOUT (if nonzero), go to FAULT.
- MEM_WAIT, Dmem_Ack=1:
  - Apply the RUN rules except the miss rule (branch, load-use, jump, or normal advance).
  - Clear the wait counter and return to RUN.
- FAULT: all Ld=0, Mem_Timeout=1. The block leaves FAULT only through reset.
- Stall_Count: increments on each edge where PC_Ld=0 and Rst=1; saturates at all-ones.
  - FAULT cycles count.

## Timing
- Hazard and flush outputs take effect in the cycle the condition is present; the pipeline registers act on the next edge.
- Load-use costs exactly 1 stall cycle; a taken branch costs 2 squashed slots; a jump costs 1.
- A memory access acked in its first MEM cycle costs 0 cycles. Each cycle of Dmem_Ack=0 adds 1 frozen cycle.
- The wait counter is ceil(log2(MEM_TIMEOUT+1)) bits wide and resets to 0.
- Asserting reset in MEM_WAIT or FAULT returns the block to RUN immediately (asynchronously) and clears Mem_Timeout.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, FAULT);
  - REG_ZERO = 5'd0;
  - the stage-control bundle typedef (Ld/Flush per stage).
- Sub-module hazard_detect: purely combinational load-use compare (ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_WriteReg → stall). It is instantiated once.

## Test plan
- Load-use: EX_MemRead=1, EX_WriteReg=8, ID_Rs=8.
  - Required: one cycle of PC_Ld=0, IF_ID_Ld=0, ID_EX_Flush=1; Stall_Count 0→1.
  - With EX_WriteReg=0 instead: no stall.
- Taken branch: EX_BranchTaken=1 together with a load-use condition.
  - Required: IF_ID_Flush=1, ID_EX_Flush=1, PC_Ld=1; no stall; Stall_Count unchanged.
- Memory wait: Dmem_Req=1 with Dmem_Ack held 0 for 3 cycles, then 1.
  - Required: 3 frozen cycles with MEM_WB_Bubble=1, then one advance cycle; Stall_Count=3; state back to RUN.
- Timeout: MEM_TIMEOUT=4 and Dmem_Ack held 0.
  - Required: FAULT entered; Mem_Timeout=1 and all Ld=0 from then on.
  - Later Dmem_Ack=1: no effect. Rst pulsed low: Mem_Timeout=0, state RUN.
- Jump: ID_Jump=1 with no other hazard. Required: IF_ID_Flush=1 for exactly 1 cycle.
- Simultaneous events: miss cycle coincident with EX_BranchTaken=1.
  - Required: no flush while frozen; both flushes asserted in the ack cycle.
